// File: rtl/conv_clause_feeder.sv
// conv_clause_feeder: clause/patch sequencer feeding the convolution PE array.
// Per clause: load the clause word, strobe it into the array, arm the array,
// sweep every window position (x outer, 8-lane y-groups middle, patch rows
// inner), let the array drain, then capture the chained clause result.
// Optional build macro: CONV_FEEDER_CNT_EN adds cyc_cnt, the per-clause cycle
// count from LOAD entry to RESULT (saturating, frozen while res_valid is high).
module conv_clause_feeder #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int DRAIN_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              num_clauses,
  input  logic [2:0]              patch_size,
  input  logic [2:0]              stride,
  input  logic                    cl_in_valid,
  output logic                    cl_in_ready,
  input  logic [255:0]            cl_in_data,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [55:0]             win_data,
  input  logic                    clause_op_in,
  output logic [255:0]            clause_write,
  output logic                    valid,
  output logic                    clause_act,
  output logic                    img_rst,
  output logic                    ipdone,
  output logic [7:0]              pe_en,
  output logic [55:0]             proc_data,
  output logic [IMG_WIDTH-1:0]    px,
  output logic [8*IMG_HEIGHT-1:0] py,
  output logic [2:0]              stride_out,
  output logic [2:0]              patch_size_out,
  output logic                    res_valid,
  output logic [7:0]              res_idx,
  output logic                    res_bit,
  output logic                    busy,
  output logic                    done
`ifdef CONV_FEEDER_CNT_EN
  ,
  output logic [31:0]             cyc_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, ARM, SWEEP, DRAIN, RESULT, CLR} state_t;

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

  state_t                  state, state_nx;
  logic [15:0]             phase_cnt;
  logic [15:0]             npos_x, npos_y;
  logic [15:0]             xpos, ybase;
  logic [2:0]              row;
  logic [7:0]              num_cl_q, clause_idx;
  logic                    vld_p0;
  logic                    row_last, yg_last, x_last, last_beat;
  logic [7:0]              lane_en;
  logic [8*IMG_HEIGHT-1:0] py_nx;

  // Window positions along one axis; a zero stride is treated as 1.
  function automatic logic [15:0] npos_calc(input logic [15:0] img, input logic [2:0] ps,
                                            input logic [2:0] st);
    logic [15:0] s;
    s = (st == 3'd0) ? 16'd1 : {13'd0, st};
    return (img - {13'd0, ps}) / s + 16'd1;
  endfunction

  function automatic logic [IMG_WIDTH-1:0] therm_x(input logic [15:0] p);
    logic [IMG_WIDTH-1:0] t;
    for (int i = 0; i < IMG_WIDTH; i++) t[i] = (16'(i) < p);
    return t;
  endfunction

  function automatic logic [IMG_HEIGHT-1:0] therm_y(input logic [15:0] p);
    logic [IMG_HEIGHT-1:0] t;
    for (int i = 0; i < IMG_HEIGHT; i++) t[i] = (16'(i) < p);
    return t;
  endfunction

  assign vld_p0    = (state == SWEEP) && win_valid;
  assign row_last  = (row == patch_size_out - 3'd1);
  assign yg_last   = ((ybase + 16'd8) >= npos_y);
  assign x_last    = (xpos == npos_x - 16'd1);
  assign last_beat = row_last && yg_last && x_last;

  // Lane enables and per-lane y codes for the current y-group.
  always_comb begin
    lane_en = '0;
    py_nx   = '0;
    for (int k = 0; k < 8; k++) begin
      lane_en[k] = ((ybase + 16'(k)) < npos_y);
      py_nx[k*IMG_HEIGHT +: IMG_HEIGHT] = therm_y(ybase + 16'(k));
    end
  end

  // Next-state logic and state-decoded array controls.
  always_comb begin
    state_nx    = state;
    cl_in_ready = 1'b0;
    valid       = 1'b0;
    clause_act  = 1'b0;
    img_rst     = 1'b0;
    ipdone      = 1'b0;
    win_ready   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:   if (start && num_clauses != 8'd0) state_nx = LOAD;
      LOAD:   begin
        cl_in_ready = 1'b1;
        if (cl_in_valid) state_nx = WRITE;
      end
      WRITE:  begin
        valid    = 1'b1;
        state_nx = ARM;
      end
      ARM:    begin
        clause_act = 1'b1;
        if (phase_cnt == 16'd1) state_nx = SWEEP;
      end
      SWEEP:  begin
        clause_act = 1'b1;
        win_ready  = 1'b1;
        if (vld_p0 && last_beat) state_nx = DRAIN;
      end
      DRAIN:  begin
        clause_act = 1'b1;
        ipdone     = 1'b1;
        if (phase_cnt == DRAIN_LAST) state_nx = RESULT;
      end
      RESULT: state_nx = CLR;
      CLR:    begin
        img_rst  = 1'b1;
        state_nx = ((clause_idx + 8'd1) == num_cl_q) ? IDLE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Run control: configuration latch, phase timer, clause index, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt      <= '0;
      npos_x         <= '0;
      npos_y         <= '0;
      num_cl_q       <= '0;
      clause_idx     <= '0;
      stride_out     <= '0;
      patch_size_out <= '0;
      done           <= 1'b0;
    end else begin
      phase_cnt <= (state_nx != state) ? 16'd0 : phase_cnt + 16'd1;
      done      <= ((state == IDLE) && start && (num_clauses == 8'd0)) ||
                   ((state == CLR) && (state_nx == IDLE));
      if (state == IDLE && start) begin
        npos_x         <= npos_calc(16'(IMG_WIDTH), patch_size, stride);
        npos_y         <= npos_calc(16'(IMG_HEIGHT), patch_size, stride);
        num_cl_q       <= num_clauses;
        clause_idx     <= '0;
        stride_out     <= stride;
        patch_size_out <= patch_size;
      end
      if (state == CLR) clause_idx <= clause_idx + 8'd1;
    end
  end

  // Sweep counters: advance only on accepted beats, cleared outside SWEEP.
  always_ff @(posedge clk) begin
    if (rst || state != SWEEP) begin
      xpos  <= '0;
      ybase <= '0;
      row   <= '0;
    end else if (vld_p0) begin
      if (row_last) begin
        row <= 3'd0;
        if (yg_last) begin
          ybase <= '0;
          xpos  <= xpos + 16'd1;
        end else begin
          ybase <= ybase + 16'd8;
        end
      end else begin
        row <= row + 3'd1;
      end
    end
  end

  // ---- stage p0 -> p1: registered array drive, clause word and result ----
  // Array-side output registers; beat fields hold on stalls, pe_en drops to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_en        <= '0;
      proc_data    <= '0;
      px           <= '0;
      py           <= '0;
      clause_write <= '0;
      res_valid    <= 1'b0;
      res_idx      <= '0;
      res_bit      <= 1'b0;
    end else begin
      pe_en <= vld_p0 ? lane_en : 8'd0;
      if (vld_p0) begin
        proc_data <= win_data;
        px        <= therm_x(xpos);
        py        <= py_nx;
      end
      if (state == LOAD && cl_in_valid) clause_write <= cl_in_data;
      res_valid <= (state == RESULT);
      if (state == RESULT) begin
        res_idx <= clause_idx;
        res_bit <= clause_op_in;
      end
    end
  end

`ifdef CONV_FEEDER_CNT_EN
  // Per-clause cycle counter: cleared on LOAD entry, runs LOAD..DRAIN, saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (state_nx == LOAD && state != LOAD) begin
      cyc_cnt <= '0;
    end else if ((state == LOAD || state == WRITE || state == ARM ||
                  state == SWEEP || state == DRAIN) && cyc_cnt != 32'hFFFF_FFFF) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/conv_clause_feeder.md
# conv_clause_feeder

Sequencer on the upstream side of the convolution processing-element array. It accepts clause words and patch-row beats, then drives the array's write/activate/reset/patch side. Per clause it loads the clause, sweeps every window position eight y-lanes at a time with thermometer position codes, waits for the array to drain, and captures the chained clause output. Sits between the clause/image buffers and the first array stage.

## Interface
- IMG_WIDTH, 32, image width in pixels.
- IMG_HEIGHT, 32, image height in pixels.
- DRAIN_CYC, 4, cycles from the last swept beat to result sampling; must be ≥ 1.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- num_clauses  in  8  clauses per image; 0 means the run finishes immediately.
- patch_size  in  3  3, 5 or 7; sampled at start.
- stride  in  3  1..7; sampled at start.
- cl_in_valid / cl_in_ready / cl_in_data  in/out/in  1/1/256  clause stream.
- win_valid / win_ready / win_data  in/out/in  1/1/56  patch-row beat; lane k is bits [7k+6:7k].
- clause_op_in  in  1  chained clause output from the last array stage.
- clause_write  out  256  registered clause word.
- valid  out  1  clause-write strobe.
- clause_act  out  1  array active.
- img_rst  out  1  array per-clause clear.
- ipdone  out  1  sweep-complete marker.
- pe_en  out  8  per-lane enable.
- proc_data  out  56  lane pixel rows, packed like win_data.
- px  out  IMG_WIDTH  x position thermometer code.
- py  out  8*IMG_HEIGHT  per-lane y codes; lane k is bits [(k+1)*IMG_HEIGHT-1 : k*IMG_HEIGHT].
- stride_out / patch_size_out  out  3/3  latched configuration.
- res_valid / res_idx / res_bit  out  1/8/1  per-clause result.
- busy / done  out  1/1  run status; done is a one-cycle pulse.

## Operation
- NPOS = (IMG − patch_size)/stride + 1, using integer division, computed separately for x and y. Values are latched at start.
- Thermometer code for position p is (1<<p)−1, zero-extended to the field width.
- FSM states:
  - IDLE: on start with num_clauses ≠ 0, go to LOAD. With num_clauses = 0, pulse done and stay in IDLE.
  - LOAD: cl_in_ready = 1. On handshake, capture cl_in_data into clause_write and go to WRITE.
  - WRITE: valid = 1 for exactly one cycle, then go to ARM.
  - ARM: clause_act = 1 for 2 cycles while the array leaves its internal reset, then go to SWEEP.
  - SWEEP: loop order is x outer, y-group (ybase = 0, 8, …) middle, patch row r = 0..patch_size−1 inner.
    - Each window consumes one win beat per row.
    - Lane k is enabled iff ybase+k < NPOS_y.
    - px and py are held constant for all patch_size rows of a window.
    - After the final beat, go to DRAIN.
  - DRAIN: ipdone = 1 for DRAIN_CYC cycles, then go to RESULT.
  - RESULT: sample clause_op_in. Pulse res_valid with res_idx = clause index, then go to CLR.
  - CLR: img_rst = 1 for one cycle and clause_act = 0. Increment the clause index. If index == num_clauses, go to IDLE and pulse done; otherwise go to LOAD.
- Stall: in SWEEP, win_ready = 1. When win_valid = 0:
  - pe_en = 0.
  - proc_data, px and py hold their values.
  - The row counter does not advance.
- Outside SWEEP, pe_en = 0 and win_ready = 0.
- clause_act is 1 in ARM, SWEEP and DRAIN; 0 in every other state.
- busy is 1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0. A mid-run reset aborts the run with no res_valid and no done.
- A start pulse while busy is ignored.
- Each accepted win beat appears on proc_data/pe_en/px/py in the next cycle (1-cycle registered latency).
- valid is asserted the cycle after the cl_in handshake.
- A simultaneous cl_in_valid and rst results in no capture.
- Per-clause overhead with no stalls: 1 (LOAD, if data is ready) + 1 + 2 + DRAIN_CYC + 1 + 1 cycles, plus sweep beats.

## Configuration
- CONV_FEEDER_CNT_EN defined: adds output cyc_cnt [31:0].
  - Counts clk cycles from LOAD entry to RESULT, per clause.
  - Cleared on LOAD entry.
  - Valid and frozen while res_valid is high.
  - Saturates at 32'hFFFF_FFFF.
- CONV_FEEDER_CNT_EN undefined: no port and no counter logic.

## Test plan
- patch 3, stride 1, 1 clause, win_valid always 1:
  - exactly 360 beats accepted;
  - last y-group pe_en = 8'h3F;
  - final px = 30'h1FFF_FFFF (p = 29);
  - one res_valid.
- patch 7, stride 2, 2 clauses:
  - 182 beats per clause;
  - last group pe_en = 8'h1F;
  - res_idx 0 then 1;
  - one done pulse;
  - img_rst pulses twice.
- Random win_valid gaps at 50% (patch 5, stride 3):
  - pe_en = 0 on every gap cycle;
  - beat count unchanged at 10×2×5 = 100.
- clause_op_in forced 1 only in RESULT of clause 1 out of 3: res_bit sequence 0, 1, 0.
- rst asserted mid-SWEEP: next cycle all outputs 0 and FSM idle; a following start runs cleanly.
- num_clauses = 0: done pulses the cycle after start; cl_in_ready is never asserted. With CONV_FEEDER_CNT_EN and patch 3, stride 1, no stalls: cyc_cnt = 360 + 4 + DRAIN_CYC.
